// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal operand entry block.
package dec_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONV    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// One nibble of the reverse double-dabble correction step.
// A nibble of 8 or more has 3 subtracted; smaller nibbles pass through.
module bcd_nibble_adjust
    import dec_entry_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    // Subtract-3 correction, the inverse of the add-3 step in the display path
    always_comb begin
        if (nib >= ADJ_THRESH) begin
            adj = nib - ADJ_SUB;
        end else begin
            adj = nib;
        end
    end

endmodule

// File: rtl/dec_operand_entry.sv
// Sequential decimal operand entry: collects BCD digits on enter presses and
// converts them to binary. DEC_ENTRY_RANGE_CHECK_EN rejects digits above 9 with err.
module dec_operand_entry
    import dec_entry_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   digit_in,
    input  logic                         enter,
    input  logic                         clear,
    input  logic                         bin_ack,
    output logic [BIN_W-1:0]             bin_out,
    output logic                         bin_valid,
    output logic                         busy,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic                         err
);

    localparam int SR_W   = DIGITS * 4;
    localparam int WORK_W = SR_W + BIN_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int ITER_W = $clog2(BIN_W + 1);

    state_t              state_r, state_s;
    logic                enter_q_r;
    logic                rise_s;
    logic [SR_W-1:0]     bcd_sr_r, bcd_sr_s;
    logic [WORK_W-1:0]   work_r, work_s;
    logic [WORK_W-1:0]   shift_s, adjusted_s;
    logic [SR_W-1:0]     adj_hi_s;
    logic [ITER_W-1:0]   iter_r, iter_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [BIN_W-1:0]    bin_out_r, bin_out_s;
    logic                busy_r, bin_valid_r;
    logic                err_r, err_s;
    logic                digit_ok_s;
    logic [3:0]          digit_cap_s;

    assign rise_s = enter & ~enter_q_r;

`ifdef DEC_ENTRY_RANGE_CHECK_EN
    assign digit_ok_s  = (digit_in <= BCD_MAX);
    assign digit_cap_s = digit_in;
`else
    assign digit_ok_s  = 1'b1;
    assign digit_cap_s = (digit_in > BCD_MAX) ? BCD_MAX : digit_in;
`endif

    // One conversion step: shift right, then correct every BCD nibble
    assign shift_s = work_r >> 1;
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nib (shift_s[BIN_W + 4*d +: 4]),
            .adj (adj_hi_s[4*d +: 4])
        );
    end
    assign adjusted_s = {adj_hi_s, shift_s[BIN_W-1:0]};

    // Next-state and datapath update; clear overrides every other event
    always_comb begin
        state_s   = state_r;
        bcd_sr_s  = bcd_sr_r;
        work_s    = work_r;
        iter_s    = iter_r;
        cnt_s     = cnt_r;
        bin_out_s = bin_out_r;
        err_s     = 1'b0;
        if (clear) begin
            state_s  = IDLE;
            cnt_s    = {CNT_W{1'b0}};
            bcd_sr_s = {SR_W{1'b0}};
            iter_s   = {ITER_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, COLLECT: begin
                    if (rise_s && digit_ok_s) begin
                        bcd_sr_s = SR_W'({bcd_sr_r, digit_cap_s});
                        cnt_s    = cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(DIGITS - 1)) begin
                            state_s = CONV;
                            work_s  = {bcd_sr_s, {BIN_W{1'b0}}};
                            iter_s  = {ITER_W{1'b0}};
                        end else begin
                            state_s = COLLECT;
                        end
                    end else if (rise_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                CONV: begin
                    work_s = adjusted_s;
                    iter_s = iter_r + ITER_W'(1);
                    if (iter_r == ITER_W'(BIN_W - 1)) begin
                        state_s   = DONE;
                        bin_out_s = adjusted_s[BIN_W-1:0];
                    end else begin
                        state_s = CONV;
                    end
                end
                DONE: begin
                    if (bin_ack) begin
                        state_s  = IDLE;
                        cnt_s    = {CNT_W{1'b0}};
                        bcd_sr_s = {SR_W{1'b0}};
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            enter_q_r   <= 1'b0;
            bcd_sr_r    <= {SR_W{1'b0}};
            work_r      <= {WORK_W{1'b0}};
            iter_r      <= {ITER_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            bin_out_r   <= {BIN_W{1'b0}};
            busy_r      <= 1'b0;
            bin_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            enter_q_r   <= enter;
            bcd_sr_r    <= bcd_sr_s;
            work_r      <= work_s;
            iter_r      <= iter_s;
            cnt_r       <= cnt_s;
            bin_out_r   <= bin_out_s;
            busy_r      <= (state_s == CONV);
            bin_valid_r <= (state_s == DONE);
            err_r       <= err_s;
        end
    end

    assign bin_out   = bin_out_r;
    assign bin_valid = bin_valid_r;
    assign busy      = busy_r;
    assign digit_cnt = cnt_r;
    assign err       = err_r;

endmodule

// File: tb/tb_dec_operand_entry.sv
// Self-checking bench for dec_operand_entry with a queue scoreboard of expected operands.
module tb_dec_operand_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       enter;
    logic       clear;
    logic       bin_ack;
    logic [6:0] bin_out;
    logic       bin_valid;
    logic       busy;
    logic [1:0] digit_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dec_operand_entry #(.DIGITS(2), .BIN_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_in  (digit_in),
        .enter     (enter),
        .clear     (clear),
        .bin_ack   (bin_ack),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .busy      (busy),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input int d);
        @(posedge clk); #1;
        digit_in = 4'(d);
        enter    = 1'b1;
        @(posedge clk); #1;
        enter    = 1'b0;
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        bin_ack = 1'b1;
        @(posedge clk); #1;
        bin_ack = 1'b0;
    endtask

    // Returns lat = negedges until bin_valid (-1 on timeout) and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_c);
        lat = -1;
        busy_c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bin_valid) begin
                lat = i;
                break;
            end
            if (busy) busy_c++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bin_out, bin_valid, busy, digit_cnt, err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%0d valid=%b busy=%b cnt=%0d err=%b, expected all 0",
                     bin_out, bin_valid, busy, digit_cnt, err);
        end
    endtask

    task automatic test_basic();
        int lat, bc, exp;
        press(4);
        @(negedge clk);
        checks++;
        if (digit_cnt !== 2'd1) begin
            errors++; $display("FAIL basic_cnt1: got %0d expected 1", digit_cnt);
        end
        press(7);
        exp_q.push_back(47);
        wait_done(lat, bc);
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        checks++;
        if (bc !== 7) begin
            errors++; $display("FAIL basic_busy: got %0d expected 7", bc);
        end
        exp = exp_q.pop_front();
        checks++;
        if (bin_out !== 7'(exp)) begin
            errors++; $display("FAIL basic_result: got %0d expected %0d", bin_out, exp);
        end
        do_ack();
        @(negedge clk);
        checks++;
        if (bin_valid !== 1'b0 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL basic_ack: got valid=%b cnt=%0d expected 0/0", bin_valid, digit_cnt);
        end
    endtask

    task automatic test_conversion();
        int pa[6] = '{9, 0, 2, 6, 0, 0};
        int pb[6] = '{9, 0, 1, 3, 0, 0};
        int lat, bc, exp;
        pa[4] = $urandom_range(0, 9); pb[4] = $urandom_range(0, 9);
        pa[5] = $urandom_range(0, 9); pb[5] = $urandom_range(0, 9);
        for (int k = 0; k < 6; k++) begin
            press(pa[k]);
            press(pb[k]);
            exp_q.push_back(pa[k] * 10 + pb[k]);
            wait_done(lat, bc);
            checks++;
            if (bc !== 7 || lat !== 8) begin
                errors++; $display("FAIL conv_timing[%0d]: got busy=%0d lat=%0d expected 7/8", k, bc, lat);
            end
            exp = exp_q.pop_front();
            checks++;
            if (bin_out !== 7'(exp)) begin
                errors++; $display("FAIL conv_result[%0d]: got %0d expected %0d", k, bin_out, exp);
            end
            do_ack();
        end
    endtask

    task automatic test_range();
        int lat, bc, exp;
        press(12);
        @(negedge clk);
`ifdef DEC_ENTRY_RANGE_CHECK_EN
        checks++;
        if (err !== 1'b1 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL range_reject: got err=%b cnt=%0d expected 1/0", err, digit_cnt);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL range_err_pulse: got err=%b expected 0", err);
        end
        press(3);
        press(5);
        exp_q.push_back(35);
`else
        checks++;
        if (err !== 1'b0 || digit_cnt !== 2'd1) begin
            errors++; $display("FAIL range_saturate: got err=%b cnt=%0d expected 0/1", err, digit_cnt);
        end
        press(3);
        exp_q.push_back(93);
`endif
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat < 0 || bin_out !== 7'(exp)) begin
            errors++; $display("FAIL range_result: got %0d (lat %0d) expected %0d", bin_out, lat, exp);
        end
        do_ack();
    endtask

    task automatic test_hold();
        int lat, bc, bad;
        press(4);
        press(7);
        wait_done(lat, bc);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            digit_in = 4'd5;
            enter    = (i % 2 == 0);
            @(negedge clk);
            if (bin_valid !== 1'b1 || bin_out !== 7'd47) bad++;
        end
        enter = 1'b0;
        checks++;
        if (lat < 0 || bad !== 0) begin
            errors++; $display("FAIL hold_stable: got %0d bad cycles (lat %0d) expected 0", bad, lat);
        end
        do_ack();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (digit_cnt !== 2'd0 || busy !== 1'b0 || bin_valid !== 1'b0) begin
            errors++; $display("FAIL hold_no_queue: got cnt=%0d busy=%b valid=%b expected 0/0/0",
                               digit_cnt, busy, bin_valid);
        end
    endtask

    task automatic test_reset_conv();
        int lat, bc, stale, exp;
        press(1);
        press(2);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_out, bin_valid, busy, digit_cnt, err} !== 12'd0) begin
            errors++; $display("FAIL rst_conv_outputs: got out=%0d valid=%b busy=%b cnt=%0d, expected 0",
                               bin_out, bin_valid, busy, digit_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bin_valid || busy) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++; $display("FAIL rst_conv_stale: got %0d stale cycles expected 0", stale);
        end
        press(2);
        press(1);
        exp_q.push_back(21);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 8 || bin_out !== 7'(exp)) begin
            errors++; $display("FAIL rst_conv_result: got %0d (lat %0d) expected %0d", bin_out, lat, exp);
        end
        do_ack();
    endtask

    task automatic test_clear();
        int lat, bc, exp;
        press(3);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (digit_cnt !== 2'd0) begin
            errors++; $display("FAIL clear_collect: got cnt=%0d expected 0", digit_cnt);
        end
        press(5);
        press(6);
        exp_q.push_back(56);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 8 || bin_out !== 7'(exp)) begin
            errors++; $display("FAIL clear_result: got %0d (lat %0d) expected %0d", bin_out, lat, exp);
        end
        @(posedge clk); #1;
        clear   = 1'b1;
        bin_ack = 1'b1;
        @(posedge clk); #1;
        clear   = 1'b0;
        bin_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bin_valid !== 1'b0 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL clear_done: got valid=%b cnt=%0d expected 0/0", bin_valid, digit_cnt);
        end
        press(8);
        press(1);
        exp_q.push_back(81);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 8 || bin_out !== 7'(exp)) begin
            errors++; $display("FAIL clear_after: got %0d (lat %0d) expected %0d", bin_out, lat, exp);
        end
        do_ack();
    endtask

    initial begin
        rst_n    = 1'b0;
        digit_in = 4'd0;
        enter    = 1'b0;
        clear    = 1'b0;
        bin_ack  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_conversion();
        test_range();
        test_hold();
        test_reset_conv();
        test_clear();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
